// File: rtl/hbridge_gate_driver.sv
// hbridge_gate_driver: H-bridge gate sequencer with dead-time insertion, fault latch and illegal-command flag.
module hbridge_gate_driver #(
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                drive_pos,
    input  logic                drive_neg,
    input  logic                brake_en,
    input  logic [DT_WIDTH-1:0] dead_time,
    input  logic                fault_n,
    input  logic                fault_clear,
    output logic                gate_ah,
    output logic                gate_al,
    output logic                gate_bh,
    output logic                gate_bl,
    output logic                fault_latched,
    output logic                in_deadtime,
    output logic                illegal_cmd
);
    typedef enum logic [2:0] {S_OFF, S_FWD, S_REV, S_BRAKE, S_DT, S_FAULT} state_t;
    state_t              state_q, state_d, tgt;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d, dt_len;
    logic                pos_q, neg_q, brk_q, sync_q, fault_s_q;
    logic                illegal_q, illegal_d;
    logic [3:0]          gates_q, gates_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_OFF;
            cnt_q     <= '0;
            pos_q     <= 1'b0;
            neg_q     <= 1'b0;
            brk_q     <= 1'b0;
            sync_q    <= 1'b1;
            fault_s_q <= 1'b1;
            illegal_q <= 1'b0;
            gates_q   <= 4'b0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pos_q     <= drive_pos;
            neg_q     <= drive_neg;
            brk_q     <= brake_en;
            sync_q    <= fault_n;
            fault_s_q <= sync_q;
            illegal_q <= illegal_d;
            gates_q   <= gates_d;
        end
    end

    always_comb begin
        tgt    = (pos_q && !neg_q) ? S_FWD :
                 (neg_q && !pos_q) ? S_REV :
                 (!pos_q && !neg_q && brk_q) ? S_BRAKE : S_OFF;
        dt_len = (dead_time == '0) ? {{(DT_WIDTH-1){1'b0}}, 1'b1} : dead_time;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!fault_s_q)
            state_d = S_FAULT;
        else if (state_q == S_FAULT)
            state_d = fault_clear ? S_OFF : S_FAULT;
        else if (!enable)
            state_d = S_OFF;
        else begin
            case (state_q)
                S_OFF: state_d = tgt;
                S_DT: begin
                    // Target is re-read only at expiry; the count itself is never reloaded here.
                    state_d = (cnt_q <= {{(DT_WIDTH-1){1'b0}}, 1'b1}) ? tgt : S_DT;
                    cnt_d   = cnt_q - 1'b1;
                end
                default: if (tgt != state_q) begin
                    state_d = S_DT;
                    cnt_d   = dt_len;
                end
            endcase
        end
    end

    // Gate flops follow the next state so they switch on the same edge as the FSM.
    always_comb begin
        gates_d   = (state_d == S_FWD)   ? 4'b1001 :
                    (state_d == S_REV)   ? 4'b0110 :
                    (state_d == S_BRAKE) ? 4'b0101 : 4'b0000;
        illegal_d = (pos_q && neg_q) || (illegal_q && !fault_clear);
    end

    assign gate_ah       = gates_q[3];
    assign gate_al       = gates_q[2];
    assign gate_bh       = gates_q[1];
    assign gate_bl       = gates_q[0];
    assign fault_latched = (state_q == S_FAULT);
    assign in_deadtime   = (state_q == S_DT);
    assign illegal_cmd   = illegal_q;
endmodule

// File: doc/hbridge_gate_driver.md
HBRIDGE_GATE_DRIVER -- requirements
Module: hbridge_gate_driver

Interface
REQ-001 SHALL have parameter DT_WIDTH, default 8, width of dead-time setting.
REQ-002 SHALL have: clk  input  1  system clock; reset reset, asynchronous, active-high; clock clk.
REQ-003 SHALL have: reset  input  1  asynchronous active-high reset.
REQ-004 SHALL have: enable  input  1  bridge enable, active-high.
REQ-005 SHALL have: drive_pos  input  1  PWM command for forward leg pair (from speed controller motor_positive).
REQ-006 SHALL have: drive_neg  input  1  PWM command for reverse leg pair (from speed controller motor_negative).
REQ-007 SHALL have: brake_en  input  1  when 1, idle command means low-side brake; when 0, idle means coast.
REQ-008 SHALL have: dead_time  input  DT_WIDTH  dead-time length in clk cycles.
REQ-009 SHALL have: fault_n  input  1  asynchronous overcurrent/desat fault, active-low.
REQ-010 SHALL have: fault_clear  input  1  single-cycle fault/flag clear request.
REQ-011 SHALL have: gate_ah, gate_al, gate_bh, gate_bl  output  1 each  registered gate drives, active-high.
REQ-012 SHALL have: fault_latched  output  1  high while in FAULT state.
REQ-013 SHALL have: in_deadtime  output  1  high while in DEADTIME state.
REQ-014 SHALL have: illegal_cmd  output  1  sticky flag, drive_pos and drive_neg sampled high together.

Function
REQ-015 SHALL register drive_pos, drive_neg, brake_en once (input stage) before decoding; fault_n SHALL pass a 2-flop synchronizer (fault_s).
REQ-016 SHALL decode target from registered inputs: pos only -> FWD; neg only -> REV; neither -> BRAKE if brake_en else OFF; both -> OFF and set illegal_cmd.
REQ-017 SHALL implement states OFF, FWD, REV, BRAKE, DEADTIME, FAULT.
REQ-018 Gate map SHALL be: FWD = AH+BL; REV = BH+AL; BRAKE = AL+BL; OFF, DEADTIME, FAULT = all gates 0.
REQ-019 Gate outputs SHALL be flops loaded from next-state decode, changing on the same edge as the state register.
REQ-020 From OFF, a conducting target SHALL be entered on the next edge with no dead time.
REQ-021 From FWD/REV/BRAKE, any target differing from current state SHALL enter DEADTIME; counter loaded with max(dead_time,1) on entry.
REQ-022 DEADTIME SHALL last exactly max(dead_time,1) cycles, then enter the target current at expiry (may be OFF or the state just left).
REQ-023 Target or dead_time changes during DEADTIME SHALL NOT restart or reload the counter.
REQ-024 Priority each cycle SHALL be: fault_s==0 > enable==0 > normal transitions.
REQ-025 fault_s==0 SHALL force FAULT on the next edge from any state, all gates 0 on that edge, bypassing DEADTIME.
REQ-026 enable==0 (no fault) SHALL force OFF on the next edge from any state except FAULT, bypassing DEADTIME.
REQ-027 FAULT SHALL exit to OFF only on fault_clear==1 while fault_s==1; fault_clear with fault_s==0 SHALL be ignored.
REQ-028 fault_clear SHALL clear illegal_cmd in any state; simultaneous new illegal sample SHALL win (flag stays 1).
REQ-029 At no time SHALL gate_ah&gate_al or gate_bh&gate_bl be 1.
REQ-030 Latency: command change at input pins, sampled edge k, SHALL appear on gates at edge k+1 from OFF, or k+1+max(dead_time,1) via DEADTIME.

Reset
REQ-031 reset SHALL asynchronously force state OFF, all gates 0, fault_latched 0, in_deadtime 0, illegal_cmd 0, input regs 0, synchronizer flops 1, dead-time counter 0.
REQ-032 Reset asserted mid-DEADTIME or in FAULT SHALL take effect immediately; after release, FSM SHALL start in OFF with fault re-evaluated through synchronizer.

Verification
REQ-033 OFF, enable=1, dead_time=4, drive_pos 0->1 -> AH,BL high 2 cycles after pin change, no DEADTIME.
REQ-034 FWD, drive_pos 1->0, drive_neg 0->1, dead_time=4 -> all gates 0 exactly 4 cycles, in_deadtime=1, then BH,AL high.
REQ-035 FWD, dead_time=0, brake_en=1, drive_pos->0 -> 1 cycle DEADTIME then AL,BL high.
REQ-036 REV, fault_n low 1 cycle -> FAULT within 3 cycles, gates 0; fault_clear while fault_n low ignored; after fault_n high, fault_clear -> OFF.
REQ-037 drive_pos=drive_neg=1 -> gates 0, illegal_cmd=1 and sticky after inputs clear; fault_clear -> 0.
REQ-038 Random drive/enable/fault stimulus, 100k cycles -> assertion REQ-029 never fails and every conducting-to-conducting change contains >=max(dead_time,1) all-off cycles.
